// File: rtl/fp_decode_queue.sv
// RISC-V F/D instruction decoder feeding a DEPTH-entry micro-op queue for an fpnew-style FPU.
// Optional macro FP_DECODE_STATS_EN adds issued/illegal pop counters (stat_issued_o, stat_illegal_o).
module fp_decode_queue #(
    parameter int unsigned DEPTH     = 4,
    parameter bit          EN_DOUBLE = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        flush_i,
    input  logic        instr_valid_i,
    input  logic [31:0] instr_rdata_i,
    output logic        instr_ready_o,
    input  logic [2:0]  frm_i,
    output logic        uop_valid_o,
    input  logic        uop_ready_i,
    output logic [4:0]  uop_rs1_o,
    output logic [4:0]  uop_rs2_o,
    output logic [4:0]  uop_rs3_o,
    output logic [4:0]  uop_rd_o,
    output logic [3:0]  uop_op_o,
    output logic        uop_op_mod_o,
    output logic [2:0]  uop_src_fmt_o,
    output logic [2:0]  uop_dst_fmt_o,
    output logic [2:0]  uop_rm_o,
    output logic        uop_load_o,
    output logic        uop_store_o,
    output logic        uop_move_o,
    output logic        uop_regwrite_o,
    output logic        uop_illegal_o
`ifdef FP_DECODE_STATS_EN
    ,
    output logic [31:0] stat_issued_o,
    output logic [31:0] stat_illegal_o
`endif
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    localparam logic [6:0] OPC_LOAD_FP  = 7'b0000111;
    localparam logic [6:0] OPC_STORE_FP = 7'b0100111;
    localparam logic [6:0] OPC_MADD     = 7'b1000011;
    localparam logic [6:0] OPC_MSUB     = 7'b1000111;
    localparam logic [6:0] OPC_NMSUB    = 7'b1001011;
    localparam logic [6:0] OPC_NMADD    = 7'b1001111;
    localparam logic [6:0] OPC_OP_FP    = 7'b1010011;

    // Encodings mirror fpnew_pkg::operation_e / fp_format_e
    localparam logic [3:0] OP_FMADD    = 4'd0;
    localparam logic [3:0] OP_FNMSUB   = 4'd1;
    localparam logic [3:0] OP_ADD      = 4'd2;
    localparam logic [3:0] OP_MUL      = 4'd3;
    localparam logic [3:0] OP_DIV      = 4'd4;
    localparam logic [3:0] OP_SQRT     = 4'd5;
    localparam logic [3:0] OP_SGNJ     = 4'd6;
    localparam logic [3:0] OP_MINMAX   = 4'd7;
    localparam logic [3:0] OP_CMP      = 4'd8;
    localparam logic [3:0] OP_CLASSIFY = 4'd9;
    localparam logic [3:0] OP_F2F      = 4'd10;
    localparam logic [3:0] OP_F2I      = 4'd11;
    localparam logic [3:0] OP_I2F      = 4'd12;

    localparam logic [2:0] FMT_FP32 = 3'd0;
    localparam logic [2:0] FMT_FP64 = 3'd1;

    typedef struct packed {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rs3;
        logic [4:0] rd;
        logic [3:0] op;
        logic       op_mod;
        logic [2:0] src_fmt;
        logic [2:0] dst_fmt;
        logic [2:0] rm;
        logic       load;
        logic       store;
        logic       move;
        logic       regwrite;
        logic       illegal;
    } uop_t;

    logic [6:0] opcode;
    logic [2:0] rm_raw;
    logic [4:0] funct5;
    logic [1:0] fmt_raw;
    logic [4:0] rs2_f;
    logic       fmt_ok;
    logic [2:0] fmt_enc;

    assign opcode  = instr_rdata_i[6:0];
    assign rm_raw  = instr_rdata_i[14:12];
    assign rs2_f   = instr_rdata_i[24:20];
    assign fmt_raw = instr_rdata_i[26:25];
    assign funct5  = instr_rdata_i[31:27];
    assign fmt_ok  = (fmt_raw == 2'b00) || ((fmt_raw == 2'b01) && EN_DOUBLE);
    assign fmt_enc = 3'(fmt_raw);

    uop_t       dec;
    logic       legal;
    logic       uses_rm;
    logic [2:0] rm_eff;

    // Combinational decode of the incoming instruction into a queue entry
    always_comb begin
        dec         = '0;
        legal       = 1'b0;
        uses_rm     = 1'b0;
        rm_eff      = rm_raw;
        dec.rs1     = instr_rdata_i[19:15];
        dec.rs2     = rs2_f;
        dec.rs3     = funct5;
        dec.rd      = instr_rdata_i[11:7];
        dec.rm      = rm_raw;
        dec.src_fmt = fmt_enc;
        dec.dst_fmt = fmt_enc;
        case (opcode)
            OPC_LOAD_FP, OPC_STORE_FP: begin
                dec.load     = (opcode == OPC_LOAD_FP);
                dec.store    = (opcode == OPC_STORE_FP);
                dec.regwrite = (opcode == OPC_LOAD_FP);
                if (rm_raw == 3'b010) begin
                    legal       = 1'b1;
                    dec.src_fmt = FMT_FP32;
                    dec.dst_fmt = FMT_FP32;
                end else if ((rm_raw == 3'b011) && EN_DOUBLE) begin
                    legal       = 1'b1;
                    dec.src_fmt = FMT_FP64;
                    dec.dst_fmt = FMT_FP64;
                end
            end
            OPC_MADD, OPC_MSUB, OPC_NMSUB, OPC_NMADD: begin
                legal        = fmt_ok;
                uses_rm      = 1'b1;
                dec.regwrite = 1'b1;
                dec.op       = (opcode == OPC_MADD || opcode == OPC_MSUB) ? OP_FMADD : OP_FNMSUB;
                dec.op_mod   = (opcode == OPC_MSUB || opcode == OPC_NMADD);
            end
            OPC_OP_FP: begin
                dec.regwrite = 1'b1;
                case (funct5)
                    5'b00000, 5'b00001: begin
                        legal      = fmt_ok;
                        uses_rm    = 1'b1;
                        dec.op     = OP_ADD;
                        dec.op_mod = funct5[0];
                    end
                    5'b00010: begin
                        legal   = fmt_ok;
                        uses_rm = 1'b1;
                        dec.op  = OP_MUL;
                    end
                    5'b00011: begin
                        legal   = fmt_ok;
                        uses_rm = 1'b1;
                        dec.op  = OP_DIV;
                    end
                    5'b01011: begin
                        legal   = fmt_ok && (rs2_f == 5'd0);
                        uses_rm = 1'b1;
                        dec.op  = OP_SQRT;
                    end
                    5'b00100: begin
                        legal  = fmt_ok && (rm_raw <= 3'b010);
                        dec.op = OP_SGNJ;
                    end
                    5'b00101: begin
                        legal  = fmt_ok && (rm_raw <= 3'b001);
                        dec.op = OP_MINMAX;
                    end
                    5'b10100: begin
                        legal  = fmt_ok && (rm_raw <= 3'b010);
                        dec.op = OP_CMP;
                    end
                    5'b11000, 5'b11010: begin
                        legal      = fmt_ok && (rs2_f[4:1] == 4'd0);
                        uses_rm    = 1'b1;
                        dec.op     = funct5[1] ? OP_I2F : OP_F2I;
                        dec.op_mod = rs2_f[0];
                    end
                    5'b01000: begin
                        // Source format comes from rs2; converting a format to itself is not encoded
                        legal       = EN_DOUBLE && fmt_ok && (rs2_f[4:1] == 4'd0)
                                      && (rs2_f[0] != fmt_raw[0]);
                        uses_rm     = 1'b1;
                        dec.op      = OP_F2F;
                        dec.src_fmt = 3'(rs2_f[0]);
                    end
                    5'b11100: begin
                        legal    = fmt_ok && (rs2_f == 5'd0) && (rm_raw <= 3'b001);
                        dec.op   = rm_raw[0] ? OP_CLASSIFY : OP_SGNJ;
                        dec.move = !rm_raw[0];
                    end
                    5'b11110: begin
                        legal    = fmt_ok && (rs2_f == 5'd0) && (rm_raw == 3'b000);
                        dec.op   = OP_SGNJ;
                        dec.move = 1'b1;
                    end
                    default: legal = 1'b0;
                endcase
            end
            default: legal = 1'b0;
        endcase
        // Dynamic rounding resolves against frm at push time; reserved modes are illegal
        if (uses_rm) begin
            rm_eff = (rm_raw == 3'b111) ? frm_i : rm_raw;
            if (rm_eff == 3'b101 || rm_eff == 3'b110 || rm_eff == 3'b111) begin
                legal = 1'b0;
            end
            dec.rm = rm_eff;
        end
        if (!legal) begin
            dec.load     = 1'b0;
            dec.store    = 1'b0;
            dec.move     = 1'b0;
            dec.regwrite = 1'b0;
            dec.illegal  = 1'b1;
        end
    end

    uop_t             mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             valid_q;
    logic             ready_q;
    logic             push;
    logic             pop;

    assign push = instr_valid_i && ready_q;
    assign pop  = valid_q && uop_ready_i;

    // Occupancy next-state; flush wins over push and pop
    always_comb begin
        count_d = count_q;
        if (flush_i) begin
            count_d = '0;
        end else if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop && !push) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            valid_q  <= 1'b0;
            ready_q  <= 1'b1;
        end else begin
            count_q <= count_d;
            valid_q <= (count_d != '0);
            ready_q <= (count_d != CNT_W'(DEPTH));
            if (flush_i) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
            end else begin
                if (push) begin
                    mem_q[wr_ptr_q] <= dec;
                    wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
                end
                if (pop) begin
                    rd_ptr_q <= rd_ptr_q + PTR_W'(1);
                end
            end
        end
    end

    uop_t head;
    assign head = mem_q[rd_ptr_q];

    assign instr_ready_o  = ready_q;
    assign uop_valid_o    = valid_q;
    assign uop_rs1_o      = head.rs1;
    assign uop_rs2_o      = head.rs2;
    assign uop_rs3_o      = head.rs3;
    assign uop_rd_o       = head.rd;
    assign uop_op_o       = head.op;
    assign uop_op_mod_o   = head.op_mod;
    assign uop_src_fmt_o  = head.src_fmt;
    assign uop_dst_fmt_o  = head.dst_fmt;
    assign uop_rm_o       = head.rm;
    assign uop_load_o     = head.load;
    assign uop_store_o    = head.store;
    assign uop_move_o     = head.move;
    assign uop_regwrite_o = head.regwrite;
    assign uop_illegal_o  = head.illegal;

`ifdef FP_DECODE_STATS_EN
    logic [31:0] issued_q;
    logic [31:0] illegal_q;

    // Pop counters survive flush; a flushed cycle does not count as a pop
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            issued_q  <= '0;
            illegal_q <= '0;
        end else if (pop && !flush_i) begin
            if (head.illegal) begin
                illegal_q <= illegal_q + 32'd1;
            end else begin
                issued_q <= issued_q + 32'd1;
            end
        end
    end

    assign stat_issued_o  = issued_q;
    assign stat_illegal_o = illegal_q;
`endif

endmodule

// File: tb/tb_fp_decode_queue.sv
// Directed bench for fp_decode_queue: decode vector table plus queue fill/drain, flush and reset sequences.
module tb_fp_decode_queue;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        instr_valid;
    logic [31:0] instr_rdata;
    logic        instr_ready;
    logic [2:0]  frm;
    logic        uop_valid;
    logic        uop_ready;
    logic [4:0]  rs1, rs2, rs3, rd;
    logic [3:0]  op;
    logic        op_mod;
    logic [2:0]  src_fmt, dst_fmt, rm;
    logic        ld, st, mv, rw, ill;

    logic        sd_instr_ready, sd_uop_valid;
    logic [4:0]  sd_rs1, sd_rs2, sd_rs3, sd_rd;
    logic [3:0]  sd_op;
    logic        sd_op_mod;
    logic [2:0]  sd_src_fmt, sd_dst_fmt, sd_rm;
    logic        sd_ld, sd_st, sd_mv, sd_rw, sd_ill;
`ifdef FP_DECODE_STATS_EN
    logic [31:0] stat_issued, stat_illegal, sd_stat_issued, sd_stat_illegal;
`endif

    fp_decode_queue #(.DEPTH(4), .EN_DOUBLE(1'b1)) dut (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
        .instr_valid_i(instr_valid), .instr_rdata_i(instr_rdata), .instr_ready_o(instr_ready),
        .frm_i(frm), .uop_valid_o(uop_valid), .uop_ready_i(uop_ready),
        .uop_rs1_o(rs1), .uop_rs2_o(rs2), .uop_rs3_o(rs3), .uop_rd_o(rd),
        .uop_op_o(op), .uop_op_mod_o(op_mod), .uop_src_fmt_o(src_fmt), .uop_dst_fmt_o(dst_fmt),
        .uop_rm_o(rm), .uop_load_o(ld), .uop_store_o(st), .uop_move_o(mv),
        .uop_regwrite_o(rw), .uop_illegal_o(ill)
`ifdef FP_DECODE_STATS_EN
        , .stat_issued_o(stat_issued), .stat_illegal_o(stat_illegal)
`endif
    );

    fp_decode_queue #(.DEPTH(4), .EN_DOUBLE(1'b0)) dut_sd (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
        .instr_valid_i(instr_valid), .instr_rdata_i(instr_rdata), .instr_ready_o(sd_instr_ready),
        .frm_i(frm), .uop_valid_o(sd_uop_valid), .uop_ready_i(uop_ready),
        .uop_rs1_o(sd_rs1), .uop_rs2_o(sd_rs2), .uop_rs3_o(sd_rs3), .uop_rd_o(sd_rd),
        .uop_op_o(sd_op), .uop_op_mod_o(sd_op_mod), .uop_src_fmt_o(sd_src_fmt),
        .uop_dst_fmt_o(sd_dst_fmt), .uop_rm_o(sd_rm), .uop_load_o(sd_ld), .uop_store_o(sd_st),
        .uop_move_o(sd_mv), .uop_regwrite_o(sd_rw), .uop_illegal_o(sd_ill)
`ifdef FP_DECODE_STATS_EN
        , .stat_issued_o(sd_stat_issued), .stat_illegal_o(sd_stat_illegal)
`endif
    );

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [2:0]  frm;
        logic [3:0]  op;
        logic        mod;
        logic [2:0]  src;
        logic [2:0]  dst;
        logic [2:0]  rm;
        logic [3:0]  flags;   // {load, store, move, regwrite}
        logic        ill;
        logic        ill_sd;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(input logic [31:0] instr, input logic [2:0] f, input logic [3:0] o,
                                input logic m, input logic [2:0] s, input logic [2:0] d,
                                input logic [2:0] r, input logic [3:0] fl, input logic il,
                                input logic ilsd);
        vec_t v;
        v.instr = instr; v.frm = f; v.op = o; v.mod = m; v.src = s; v.dst = d;
        v.rm = r; v.flags = fl; v.ill = il; v.ill_sd = ilsd;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_one(input logic [31:0] instr, input logic [2:0] f);
        @(negedge clk);
        instr_valid = 1'b1; instr_rdata = instr; frm = f;
        @(negedge clk);
        instr_valid = 1'b0; frm = 3'b000;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    logic [31:0] fill [5];
    int idx, got, cyc;

    initial begin
        clk = 1'b0; rst_n = 1'b0; flush = 1'b0; instr_valid = 1'b0;
        instr_rdata = '0; frm = '0; uop_ready = 1'b0;

        // Decode table: hand-computed fpnew fields for EN_DOUBLE=1 and illegal flag for EN_DOUBLE=0
        vq.push_back(mk(32'h00208053, 3'd0, 4'd2,  1'b0, 3'd0, 3'd0, 3'd0, 4'b0001, 1'b0, 1'b0)); // FADD.S
        vq.push_back(mk(32'h08209053, 3'd0, 4'd2,  1'b1, 3'd0, 3'd0, 3'd1, 4'b0001, 1'b0, 1'b0)); // FSUB.S rtz
        vq.push_back(mk(32'h1020F1D3, 3'd2, 4'd3,  1'b0, 3'd0, 3'd0, 3'd2, 4'b0001, 1'b0, 1'b0)); // FMUL.S dyn
        vq.push_back(mk(32'h1020F1D3, 3'd5, 4'd0,  1'b0, 3'd0, 3'd0, 3'd0, 4'b0000, 1'b1, 1'b1)); // dyn, bad frm
        vq.push_back(mk(32'h1020D1D3, 3'd0, 4'd0,  1'b0, 3'd0, 3'd0, 3'd0, 4'b0000, 1'b1, 1'b1)); // rm=101
        vq.push_back(mk(32'h0000B007, 3'd0, 4'd0,  1'b0, 3'd1, 3'd1, 3'd3, 4'b1001, 1'b0, 1'b1)); // FLD
        vq.push_back(mk(32'h0000A007, 3'd0, 4'd0,  1'b0, 3'd0, 3'd0, 3'd2, 4'b1001, 1'b0, 1'b0)); // FLW
        vq.push_back(mk(32'h00003027, 3'd0, 4'd0,  1'b0, 3'd1, 3'd1, 3'd3, 4'b0100, 1'b0, 1'b1)); // FSD
        vq.push_back(mk(32'h02208053, 3'd0, 4'd2,  1'b0, 3'd1, 3'd1, 3'd0, 4'b0001, 1'b0, 1'b1)); // FADD.D
        vq.push_back(mk(32'h04208053, 3'd0, 4'd0,  1'b0, 3'd0, 3'd0, 3'd0, 4'b0000, 1'b1, 1'b1)); // fmt=10
        vq.push_back(mk(32'h00000043, 3'd0, 4'd0,  1'b0, 3'd0, 3'd0, 3'd0, 4'b0001, 1'b0, 1'b0)); // FMADD.S
        vq.push_back(mk(32'h0000004F, 3'd0, 4'd1,  1'b1, 3'd0, 3'd0, 3'd0, 4'b0001, 1'b0, 1'b0)); // FNMADD.S
        vq.push_back(mk(32'h58008053, 3'd0, 4'd5,  1'b0, 3'd0, 3'd0, 3'd0, 4'b0001, 1'b0, 1'b0)); // FSQRT.S
        vq.push_back(mk(32'h58208053, 3'd0, 4'd0,  1'b0, 3'd0, 3'd0, 3'd0, 4'b0000, 1'b1, 1'b1)); // sqrt rs2!=0
        vq.push_back(mk(32'h2020A053, 3'd0, 4'd6,  1'b0, 3'd0, 3'd0, 3'd2, 4'b0001, 1'b0, 1'b0)); // FSGNJX.S
        vq.push_back(mk(32'h2020B053, 3'd0, 4'd0,  1'b0, 3'd0, 3'd0, 3'd0, 4'b0000, 1'b1, 1'b1)); // sgnj rm=011
        vq.push_back(mk(32'hA0208053, 3'd0, 4'd8,  1'b0, 3'd0, 3'd0, 3'd0, 4'b0001, 1'b0, 1'b0)); // FLE.S
        vq.push_back(mk(32'hC0109053, 3'd0, 4'd11, 1'b1, 3'd0, 3'd0, 3'd1, 4'b0001, 1'b0, 1'b0)); // FCVT.WU.S
        vq.push_back(mk(32'hD0008053, 3'd0, 4'd12, 1'b0, 3'd0, 3'd0, 3'd0, 4'b0001, 1'b0, 1'b0)); // FCVT.S.W
        vq.push_back(mk(32'h40108053, 3'd0, 4'd10, 1'b0, 3'd1, 3'd0, 3'd0, 4'b0001, 1'b0, 1'b1)); // FCVT.S.D
        vq.push_back(mk(32'h42008053, 3'd0, 4'd10, 1'b0, 3'd0, 3'd1, 3'd0, 4'b0001, 1'b0, 1'b1)); // FCVT.D.S
        vq.push_back(mk(32'hE0008053, 3'd0, 4'd6,  1'b0, 3'd0, 3'd0, 3'd0, 4'b0011, 1'b0, 1'b0)); // FMV.X.W
        vq.push_back(mk(32'hE0009053, 3'd0, 4'd9,  1'b0, 3'd0, 3'd0, 3'd1, 4'b0001, 1'b0, 1'b0)); // FCLASS.S
        vq.push_back(mk(32'hF0008053, 3'd0, 4'd6,  1'b0, 3'd0, 3'd0, 3'd0, 4'b0011, 1'b0, 1'b0)); // FMV.W.X
        vq.push_back(mk(32'h00000013, 3'd0, 4'd0,  1'b0, 3'd0, 3'd0, 3'd0, 4'b0000, 1'b1, 1'b1)); // ADDI
        vq.push_back(mk(32'h2820A053, 3'd0, 4'd0,  1'b0, 3'd0, 3'd0, 3'd0, 4'b0000, 1'b1, 1'b1)); // minmax rm=010
        vq.push_back(mk(32'h28209053, 3'd0, 4'd7,  1'b0, 3'd0, 3'd0, 3'd1, 4'b0001, 1'b0, 1'b0)); // FMAX.S
        vq.push_back(mk(32'h0020F053, 3'd7, 4'd0,  1'b0, 3'd0, 3'd0, 3'd0, 4'b0000, 1'b1, 1'b1)); // dyn, frm=111

        #12 rst_n = 1'b1;
        #1;
        chk("reset uop_valid", 32'(uop_valid), 32'd0);
        chk("reset instr_ready", 32'(instr_ready), 32'd1);
        chk("reset fields", {rs1, rs2, rs3, rd, op, op_mod, src_fmt, dst_fmt, rm},
            32'd0);
        chk("reset flags", {ld, st, mv, rw, ill}, 32'd0);

        foreach (vq[i]) begin
            push_one(vq[i].instr, vq[i].frm);
            chk($sformatf("v%0d valid", i), 32'(uop_valid), 32'd1);
            chk($sformatf("v%0d illegal", i), 32'(ill), 32'(vq[i].ill));
            chk($sformatf("v%0d flags", i), {ld, st, mv, rw}, 32'(vq[i].flags));
            chk($sformatf("v%0d sd illegal", i), 32'(sd_ill), 32'(vq[i].ill_sd));
            if (vq[i].ill_sd) chk($sformatf("v%0d sd flags", i), {sd_ld, sd_st, sd_mv, sd_rw}, 32'd0);
            if (!vq[i].ill) begin
                chk($sformatf("v%0d op/mod", i), {op, op_mod}, {vq[i].op, vq[i].mod});
                chk($sformatf("v%0d fmt", i), {src_fmt, dst_fmt}, {vq[i].src, vq[i].dst});
                chk($sformatf("v%0d rm", i), 32'(rm), 32'(vq[i].rm));
                chk($sformatf("v%0d regs", i), {rs1, rs2, rs3, rd},
                    {vq[i].instr[19:15], vq[i].instr[24:20], vq[i].instr[31:27], vq[i].instr[11:7]});
            end
            uop_ready = 1'b1;
            @(negedge clk);
            uop_ready = 1'b0;
            chk($sformatf("v%0d popped", i), 32'(uop_valid), 32'd0);
        end

        // Fill with consumer stalled, then drain: order kept, 5th held until space
        for (int k = 0; k < 5; k++) fill[k] = 32'h00208053 | (32'(k + 1) << 7);
        idx = 0; cyc = 0;
        while (idx < 4 && cyc < 20) begin
            @(negedge clk);
            cyc++;
            instr_valid = 1'b1; instr_rdata = fill[idx];
            if (instr_ready) idx++;
        end
        @(negedge clk);
        instr_rdata = fill[4];
        chk("full instr_ready", 32'(instr_ready), 32'd0);
        @(negedge clk);
        @(negedge clk);
        chk("stall instr_ready", 32'(instr_ready), 32'd0);
        chk("stall head rd", 32'(rd), 32'd1);
        chk("stall valid", 32'(uop_valid), 32'd1);
        got = 0; cyc = 0;
        while (got < 5 && cyc < 40) begin
            if (cyc > 0) @(negedge clk);
            cyc++;
            uop_ready = 1'b1;
            if (idx < 5) begin
                instr_valid = 1'b1; instr_rdata = fill[idx];
            end else begin
                instr_valid = 1'b0;
            end
            if (uop_valid) begin
                chk($sformatf("drain order %0d", got), 32'(rd), 32'(got + 1));
                got++;
            end
            if (idx < 5 && instr_ready) idx++;
        end
        chk("drain count", 32'(got), 32'd5);
        chk("drain pushed", 32'(idx), 32'd5);
        @(negedge clk);
        uop_ready = 1'b0;
        chk("drain no dup", 32'(uop_valid), 32'd0);

        // Flush with three queued entries and a concurrent push
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            instr_valid = 1'b1; instr_rdata = fill[k];
        end
        @(negedge clk);
        chk("pre-flush valid", 32'(uop_valid), 32'd1);
        flush = 1'b1; instr_rdata = fill[3];
        @(negedge clk);
        flush = 1'b0; instr_valid = 1'b0;
        chk("flush valid", 32'(uop_valid), 32'd0);
        chk("flush ready", 32'(instr_ready), 32'd1);
        push_one(fill[4], 3'd0);
        chk("post-flush head rd", 32'(rd), 32'd5);
        uop_ready = 1'b1;
        @(negedge clk);
        uop_ready = 1'b0;
        chk("post-flush empty", 32'(uop_valid), 32'd0);

        // Async reset mid-operation
        push_one(fill[0], 3'd0);
        push_one(fill[1], 3'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("async reset valid", 32'(uop_valid), 32'd0);
        chk("async reset ready", 32'(instr_ready), 32'd1);
        #3 rst_n = 1'b1;

`ifdef FP_DECODE_STATS_EN
        chk("stats reset issued", stat_issued, 32'd0);
        push_one(32'h00208053, 3'd0);
        push_one(32'h00000013, 3'd0);
        push_one(32'h1020F1D3, 3'd2);
        push_one(32'h04208053, 3'd0);
        push_one(32'h0000A007, 3'd0);
        uop_ready = 1'b1;
        repeat (6) @(negedge clk);
        uop_ready = 1'b0;
        chk("stats issued", stat_issued, 32'd3);
        chk("stats illegal", stat_illegal, 32'd2);
        #2 rst_n = 1'b0;
        #1;
        chk("stats reset issued after", stat_issued, 32'd0);
        chk("stats reset illegal after", stat_illegal, 32'd0);
        #3 rst_n = 1'b1;
`endif

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
